// File: rtl/result_display_formatter.sv
// Formats a 16-bit calculator result as four seven-segment nibbles: range check,
// sequential shift-add-3 binary-to-BCD, leading-zero blanking and minus-sign placement.
module result_display_formatter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        signed_mode,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  extra_char,
  output logic        busy,
  output logic        valid,
  output logic        error
);

  localparam int unsigned VAL_W  = 16;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NIB_N  = 4;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [VAL_W-1:0] MAX_POS    = VAL_W'(9999);
  localparam logic [VAL_W-1:0] MAX_NEG    = VAL_W'(999);
  localparam logic [BCD_W-1:0] BLANK_DIGITS = 16'h7777;
  localparam logic [BCD_W-1:0] ERR_DIGITS   = 16'hE007;
  localparam logic [3:0]       ERR_MASK     = 4'b0111;
  localparam logic [3:0]       CODE_NEG     = 4'd1;
  localparam logic [3:0]       CODE_BLANK   = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_FORMAT} state_t;

  state_t             state, state_d;
  logic [VAL_W-1:0]   value_q;
  logic               signed_q;
  logic               neg_q;
  logic               err_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               neg_c;
  logic [VAL_W-1:0]   mag_c;
  logic               range_err_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W-1:0]   fmt_digits_c;
  logic [3:0]         fmt_mask_c;
  logic               blank1_c, blank2_c, blank3_c;

  // Sign and magnitude of the captured value, plus the display range check
  always_comb begin
    neg_c       = signed_q & value_q[VAL_W-1];
    mag_c       = neg_c ? VAL_W'(~value_q + VAL_W'(1)) : value_q;
    range_err_c = neg_c ? (mag_c > MAX_NEG) : (mag_c > MAX_POS);
  end

  // Add-3 correction applied before every shift
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < NIB_N; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj_c[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (load) state_d = S_CHECK;
      S_CHECK:  state_d = range_err_c ? S_FORMAT : S_SHIFT;
      S_SHIFT:  if (cnt_q == LAST_SHIFT) state_d = S_FORMAT;
      S_FORMAT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  // Display image: blank leading zeros, then put the minus sign left of the top shown digit
  always_comb begin
    blank3_c     = (bcd_q[15:12] == 4'd0);
    blank2_c     = blank3_c & (bcd_q[11:8] == 4'd0);
    blank1_c     = blank2_c & (bcd_q[7:4] == 4'd0);
    fmt_digits_c = bcd_q;
    fmt_mask_c   = 4'b0000;
    if (blank3_c) begin fmt_digits_c[15:12] = CODE_BLANK; fmt_mask_c[3] = 1'b1; end
    if (blank2_c) begin fmt_digits_c[11:8]  = CODE_BLANK; fmt_mask_c[2] = 1'b1; end
    if (blank1_c) begin fmt_digits_c[7:4]   = CODE_BLANK; fmt_mask_c[1] = 1'b1; end
    if (neg_q) begin
      if (blank1_c)      fmt_digits_c[7:4]   = CODE_NEG;
      else if (blank2_c) fmt_digits_c[11:8]  = CODE_NEG;
      else               fmt_digits_c[15:12] = CODE_NEG;
    end
    if (err_q) begin
      fmt_digits_c = ERR_DIGITS;
      fmt_mask_c   = ERR_MASK;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q    <= '0;
      signed_q   <= 1'b0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      digits     <= BLANK_DIGITS;
      extra_char <= 4'b1111;
      busy       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        digits     <= BLANK_DIGITS;
        extra_char <= 4'b1111;
        busy       <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (load) begin
              value_q  <= value;
              signed_q <= signed_mode;
              busy     <= 1'b1;
            end
          end
          S_CHECK: begin
            neg_q <= neg_c;
            err_q <= range_err_c;
            bin_q <= mag_c[BIN_W-1:0];
            bcd_q <= '0;
            cnt_q <= '0;
          end
          S_SHIFT: begin
            bcd_q <= {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_q <= {bin_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q + CNT_W'(1);
          end
          S_FORMAT: begin
            digits     <= fmt_digits_c;
            extra_char <= fmt_mask_c;
            error      <= err_q;
            valid      <= 1'b1;
            busy       <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
